// File: rtl/mem_stream_reader.sv
// Scans a word range of the data RAM and serialises each word, LSB byte first, onto an 8-bit valid/ready stream.
// Optional trailing XOR checksum byte is enabled by defining MEM_STREAM_READER_CHECKSUM_EN.
module mem_stream_reader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic              busy,
  output logic              done,
  output logic              mem_rden,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_q,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int NBYTES = DATA_W / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LATCH = 3'd2,
    SEND  = 3'd3,
    CSUM  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] remaining;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_next;
  logic [IDX_W-1:0]  idx;
  logic              xfer;
  logic              last_byte;
`ifdef MEM_STREAM_READER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign shift_next = shift >> 8;
  assign xfer       = tx_valid & tx_ready;
  assign last_byte  = (idx == IDX_W'(NBYTES - 1));

  // Scan sequencer; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rden  <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      addr      <= {ADDR_W{1'b0}};
      remaining <= {ADDR_W{1'b0}};
      shift     <= {DATA_W{1'b0}};
      idx       <= {IDX_W{1'b0}};
`ifdef MEM_STREAM_READER_CHECKSUM_EN
      csum      <= 8'h00;
`endif
    end else begin
      done     <= 1'b0;
      mem_rden <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (word_count != {ADDR_W{1'b0}}) begin
              addr      <= base_addr;
              remaining <= word_count;
              mem_addr  <= base_addr;
              mem_rden  <= 1'b1;
              state     <= READ;
`ifdef MEM_STREAM_READER_CHECKSUM_EN
              csum      <= 8'h00;
`endif
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        READ: begin
          state <= LATCH;
        end
        LATCH: begin
          shift    <= mem_q;
          tx_data  <= mem_q[7:0];
          tx_valid <= 1'b1;
          idx      <= {IDX_W{1'b0}};
          state    <= SEND;
        end
        SEND: begin
          if (xfer) begin
`ifdef MEM_STREAM_READER_CHECKSUM_EN
            csum <= csum ^ tx_data;
`endif
            if (last_byte) begin
              remaining <= remaining - ADDR_W'(1);
              addr      <= addr + ADDR_W'(1);
              if (remaining != ADDR_W'(1)) begin
                mem_addr <= addr + ADDR_W'(1);
                mem_rden <= 1'b1;
                tx_valid <= 1'b0;
                state    <= READ;
              end else begin
`ifdef MEM_STREAM_READER_CHECKSUM_EN
                // Final byte folds into the checksum in the same cycle it leaves.
                tx_data <= csum ^ tx_data;
                state   <= CSUM;
`else
                tx_valid <= 1'b0;
                done     <= 1'b1;
                state    <= DONE;
`endif
              end
            end else begin
              shift   <= shift_next;
              tx_data <= shift_next[7:0];
              idx     <= idx + IDX_W'(1);
            end
          end else begin
            state <= SEND;
          end
        end
        CSUM: begin
          if (xfer) begin
            tx_valid <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            state <= CSUM;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy     <= 1'b0;
          tx_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_stream_reader.md
# mem_stream_reader

Read-side counterpart to the pipelined vector processor's data-memory writes. After a program has written a result buffer (48-bit vector words) into the data RAM, this block scans a word range of that RAM through its read port and serialises each word into an 8-bit valid/ready byte stream for an off-chip link such as a UART transmitter or a debug FIFO. It owns the RAM read port while busy. A start pulse triggers it, and it reports completion with a one-cycle done pulse.

## Interface
- `ADDR_W`, 16, RAM word-address width.
- `DATA_W`, 48, RAM word width. Must be a multiple of 8. `NBYTES = DATA_W/8`.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  one-cycle request to begin a scan. Sampled only in IDLE.
- `base_addr`  in  ADDR_W  first word address. Latched on an accepted start.
- `word_count`  in  ADDR_W  number of words to send. Latched on an accepted start.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse at the end of a scan.
- `mem_rden`  out  1  RAM read enable.
- `mem_addr`  out  ADDR_W  RAM read address, registered.
- `mem_q`  in  DATA_W  RAM read data. Valid in the cycle after the cycle in which `mem_rden` is high.
- `tx_data`  out  8  stream byte.
- `tx_valid`  out  1  stream byte valid.
- `tx_ready`  in  1  sink accepts; a transfer occurs when `tx_valid & tx_ready`.

## Operation
- States: IDLE, READ, LATCH, SEND, CSUM, DONE.
- IDLE
  - `start=1` with `word_count≠0`: latch address and count, go to READ.
  - `start=1` with `word_count=0`: go to DONE. No RAM access, no bytes, no checksum.
- READ: `mem_rden=1` and `mem_addr`=current address, for one cycle. Go to LATCH.
- LATCH: capture `mem_q` into an internal shift register and reset the byte index to 0. Go to SEND.
- SEND
  - `tx_valid=1`; `tx_data` = byte[index], LSB byte first (byte 0 = bits 7:0).
  - On each transfer, increment the index.
  - After byte `NBYTES-1` transfers:
    - decrement the remaining count and increment the address;
    - if words remain, go to READ;
    - otherwise go to CSUM (macro defined) or DONE (macro undefined).
- CSUM: `tx_valid=1`, `tx_data` = running checksum. On transfer, go to DONE.
- DONE: `done=1` for one cycle, then IDLE.
- The address increments modulo 2^ADDR_W; 0xFFFF wraps to 0x0000 when ADDR_W=16.
- `start` is ignored in every state other than IDLE. Port changes on `base_addr` and `word_count` have no effect after latching.
- `mem_rden` is low in every state except READ. `mem_addr` holds its last value when not reading.

## Timing
- Reset values: `busy=0`, `done=0`, `mem_rden=0`, `mem_addr=0`, `tx_valid=0`, `tx_data=0`. The state returns to IDLE and the checksum clears to 0.
- Let `start` be accepted in cycle N:
  - READ in N+1;
  - LATCH in N+2;
  - first `tx_valid` in N+3.
- With `tx_ready` held at 1, each word occupies NBYTES+2 cycles.
- While `tx_valid=1` and `tx_ready=0`, `tx_data` and the state are held stable. `tx_valid` never drops without a transfer, except on `rst`.
- `tx_valid` is combinationally independent of `tx_ready`.
- `rst` asserted mid-scan: at that edge, return to IDLE with reset output values. The partial word is discarded and no `done` pulse is issued.
- `done` and `busy` are both high in the DONE cycle. `busy` is 0 in the following cycle, and a new `start` can be accepted in that cycle.

## Configuration
- `MEM_STREAM_READER_CHECKSUM_EN` defined:
  - maintain an 8-bit XOR of every data byte transferred in the scan;
  - emit it as one extra byte (CSUM state) after the last word and before DONE;
  - clear the checksum on an accepted start.
- Undefined: no CSUM state and no checksum register; the last data byte is followed directly by DONE.

## Test plan
- Single word, no backpressure:
  - Stimulus: RAM[0x0010]=0x0A0B0C0D0E0F; start at N with base=0x0010, count=1; `tx_ready=1`.
  - Bytes 0F,0E,0D,0C,0B,0A are accepted in cycles N+3..N+8.
  - Macro undefined: `done` pulses at N+9.
  - Macro defined: byte 0x01 at N+9 and `done` at N+10.
- Backpressure:
  - Stimulus: two words; `tx_ready` low for 3 cycles while byte 2 is valid.
  - `tx_data` stays equal to byte 2 with `tx_valid=1` throughout the stall.
  - Byte order is unchanged, and the total stream is 12 data bytes.
- Zero count: start with count=0 -> `done` at N+1, `tx_valid` never asserts, `mem_rden` never asserts.
- Address wrap: ADDR_W=16, base=0xFFFF, count=2 -> `mem_rden` cycles present 0xFFFF and then 0x0000.
- Reset mid-stream: `rst` asserted after the 3rd byte of a word -> next cycle all outputs are at reset values and no `done` pulse occurs. A fresh start then streams correctly from its own base.
- Start while busy: a second start pulse during SEND with a different base -> ignored; the original scan completes with the original addresses.
